regfile_mp: RTL

- Parametrised successor to the single-write integer register file.
- Provides NUM_RD combinational read ports and two synchronous write ports: A for ALU/retire, B for load return.
- Optional write-to-read bypass.
- Per-register pending scoreboard for load-use hazard detection.
- Hardware clear sequencer that zeroes the array after reset. Sits between decode (reads and claims) and writeback (writes) in the core.

---
 rtl/regfile_mp.sv | 72 +++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, optional write bypass,
// load-use pending scoreboard and a clear sequencer that zeroes the array after reset.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int SELW = $clog2(NUM_REGS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_RD*SELW-1:0] i_rd_sel,
  output logic [NUM_RD*XLEN-1:0] o_rd_val,
  output logic [NUM_RD-1:0]      o_rd_busy,
  input  logic                   i_wa_en,
  input  logic [SELW-1:0]        i_wa_sel,
  input  logic [XLEN-1:0]        i_wa_data,
  input  logic                   i_wb_en,
  input  logic [SELW-1:0]        i_wb_sel,
  input  logic [XLEN-1:0]        i_wb_data,
  input  logic                   i_claim_en,
  input  logic [SELW-1:0]        i_claim_sel,
  output logic                   o_ready
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  state_t state, state_n;
  logic [SELW-1:0] ptr;
  logic ready;
  logic [NUM_REGS-1:0] pend, pend_n;
  logic [XLEN-1:0] regs [NUM_REGS];
  assign o_ready = ready;
  // claim is applied after the B-write release so a same-cycle claim wins
  always_comb begin
    state_n = (state == CLEAR && ptr == SELW'(NUM_REGS - 1)) ? RUN : state;
    pend_n = pend;
    if (ready && i_wb_en) pend_n[i_wb_sel] = 1'b0;
    if (ready && i_claim_en) pend_n[i_claim_sel] = 1'b1;
    pend_n[0] = 1'b0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RST_STATE;
      ptr <= SELW'(1);
      ready <= 1'b0;
      pend <= '0;
    end else begin
      state <= state_n;
      ptr <= (state == CLEAR) ? ptr + 1'b1 : ptr;
      ready <= (state_n == RUN);
      pend <= pend_n;
    end
  end
  // port A is written last so it overrides port B on an address collision
  always_ff @(posedge i_clk) begin
    if (state == CLEAR) regs[ptr] <= '0;
    else if (ready) begin
      if (i_wb_en && i_wb_sel != '0) regs[i_wb_sel] <= i_wb_data;
      if (i_wa_en && i_wa_sel != '0) regs[i_wa_sel] <= i_wa_data;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [SELW-1:0] sel;
    logic wa_hit, wb_hit;
    assign sel = i_rd_sel[k*SELW +: SELW];
    assign wa_hit = (BYPASS != 0) && i_wa_en && i_wa_sel == sel;
    assign wb_hit = (BYPASS != 0) && i_wb_en && i_wb_sel == sel;
    assign o_rd_val[k*XLEN +: XLEN] = (!ready || sel == '0) ? '0 : wa_hit ? i_wa_data : wb_hit ? i_wb_data : regs[sel];
    assign o_rd_busy[k] = ready && sel != '0 && pend[sel] && !wb_hit;
  end
endmodule
